// File: rtl/tl45_pkg.sv
// tl45_pkg: types and constants shared by the TL45 pipeline stages.
//   TL45_NOP            - instruction word presented as a bubble
//   fetch_state_t       - fetch bus FSM states
//   tl45_waddr_t        - 30-bit Wishbone word address
//   tl45_fetch_slot_t   - {pc, inst} pair handed from fetch to decode
package tl45_pkg;

    localparam int unsigned TL45_XLEN  = 32;
    localparam int unsigned TL45_WAW   = 30;

    localparam logic [TL45_XLEN-1:0] TL45_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    typedef logic [TL45_WAW-1:0] tl45_waddr_t;

    typedef struct packed {
        logic [TL45_XLEN-1:0] pc;
        logic [TL45_XLEN-1:0] inst;
    } tl45_fetch_slot_t;

endpackage

// File: rtl/tl45_perf_counter.sv
// tl45_perf_counter: free-running event counter, wraps at 2^WIDTH.
//   i_clk    - clock (posedge)
//   i_reset  - synchronous active-high clear
//   i_inc    - count one event on this edge
//   o_count  - current count
module tl45_perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_inc) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tl45_fetch.sv
// tl45_fetch: first pipeline stage. Owns the PC, fetches instruction words over a
// pipelined Wishbone master (one outstanding request) and presents {pc, inst} to
// decode, inserting NOP bubbles when nothing is ready. A one-entry skid register
// absorbs a word that returns while decode is stalled on a real instruction.
//   i_clk, i_reset          - clock, synchronous active-high reset
//   i_pipe_stall            - decode did not consume o_buf_* this edge
//   i_pipe_flush, i_new_pc  - redirect to i_new_pc (bits [1:0] forced 0)
//   o_buf_pc, o_buf_inst    - presented instruction (0/0 = bubble)
//   o_fetch_err             - sticky bus-error flag, cleared by flush/reset
//   o_wb_cyc/stb/addr       - Wishbone master request (addr = pc[31:2])
//   i_wb_stall/ack/err/data - Wishbone slave response
// Build option: define TL45_FETCH_PERF_EN to add o_perf_fetched (acks delivered)
// and o_perf_bubbles (non-stall edges loading a bubble).
module tl45_fetch
    import tl45_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic [31:0] i_new_pc,
    output logic [31:0] o_buf_pc,
    output logic [31:0] o_buf_inst,
    output logic        o_fetch_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [29:0] o_wb_addr,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data
`ifdef TL45_FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_bubbles
`endif
);

    fetch_state_t     r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic             r_cyc, w_cyc_nxt;
    logic             r_stb, w_stb_nxt;
    logic             r_err, w_err_nxt;
    tl45_fetch_slot_t r_out, r_skid, w_ack_slot, w_bubble;
    logic             r_out_valid, r_skid_valid;
    logic             w_ack, w_bus_err, w_to_skid;
    logic [31:0]      w_flush_pc;

    // Responses only count while a request is outstanding; stray acks are dropped.
    assign w_bus_err  = (r_state == WAIT) && i_wb_err;
    assign w_ack      = (r_state == WAIT) && i_wb_ack && !i_wb_err;
    assign w_to_skid  = w_ack && i_pipe_stall && r_out_valid;
    assign w_ack_slot = '{pc: r_pc, inst: i_wb_data};
    assign w_bubble   = '{pc: 32'h0, inst: TL45_NOP};
    assign w_flush_pc = i_new_pc & 32'hFFFF_FFFC;

    // Bus FSM next-state and request outputs
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cyc_nxt   = r_cyc;
        w_stb_nxt   = r_stb;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                // A new request only goes out once the skid has drained.
                if (!r_skid_valid) begin
                    w_state_nxt = REQ;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                end
            end
            REQ: begin
                if (!i_wb_stall) begin
                    w_state_nxt = WAIT;
                    w_stb_nxt   = 1'b0;
                end
            end
            WAIT: begin
                if (w_bus_err) begin
                    w_state_nxt = HALT;
                    w_cyc_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                end else if (w_ack) begin
                    w_pc_nxt = r_pc + 32'd4;
                    if (w_to_skid) begin
                        w_state_nxt = IDLE;
                        w_cyc_nxt   = 1'b0;
                    end else begin
                        // Back-to-back request keeps a zero-wait slave at 1 word / 2 cycles.
                        w_state_nxt = REQ;
                        w_stb_nxt   = 1'b1;
                    end
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
            end
        endcase
    end

    // Bus FSM state register; reset beats flush, flush beats everything else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_pipe_flush) begin
            r_state <= IDLE;
            r_pc    <= w_flush_pc;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cyc   <= w_cyc_nxt;
            r_stb   <= w_stb_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Output and skid registers; the skid is only filled when output holds a real word
    always_ff @(posedge i_clk) begin
        if (i_reset || i_pipe_flush) begin
            r_out        <= w_bubble;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!i_pipe_stall) begin
            if (w_ack) begin
                r_out       <= w_ack_slot;
                r_out_valid <= 1'b1;
            end else if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out       <= w_bubble;
                r_out_valid <= 1'b0;
            end
        end else if (w_ack) begin
            if (!r_out_valid) begin
                r_out       <= w_ack_slot;
                r_out_valid <= 1'b1;
            end else begin
                r_skid       <= w_ack_slot;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_buf_pc    = r_out.pc;
    assign o_buf_inst  = r_out.inst;
    assign o_fetch_err = r_err;
    assign o_wb_cyc    = r_cyc;
    assign o_wb_stb    = r_stb;
    assign o_wb_addr   = tl45_waddr_t'(r_pc[31:2]);

`ifdef TL45_FETCH_PERF_EN
    logic w_perf_fetch, w_perf_bubble;

    // Flush edges discard whatever they would have loaded, so they count as neither.
    assign w_perf_fetch  = w_ack && !i_pipe_flush;
    assign w_perf_bubble = !i_pipe_stall && !i_pipe_flush && !w_ack && !r_skid_valid;

    tl45_perf_counter #(.WIDTH(32)) u_perf_fetched (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_perf_fetch),
        .o_count (o_perf_fetched)
    );

    tl45_perf_counter #(.WIDTH(32)) u_perf_bubbles (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_perf_bubble),
        .o_count (o_perf_bubbles)
    );
`endif

endmodule

// File: tb/tb_tl45_fetch.sv
// tb_tl45_fetch: self-checking bench for tl45_fetch. A behavioural Wishbone slave
// (configurable stall/latency/error) serves words from a synthetic memory; a stream
// model tracks the PC decode must see next and checks every consumed instruction.
module tb_tl45_fetch;
    import tl45_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipe_stall = 1'b0;
    logic        i_pipe_flush = 1'b0;
    logic [31:0] i_new_pc = 32'h0;
    logic [31:0] o_buf_pc, o_buf_inst;
    logic        o_fetch_err, o_wb_cyc, o_wb_stb;
    logic [29:0] o_wb_addr;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic [31:0] i_wb_data = 32'h0;
`ifdef TL45_FETCH_PERF_EN
    logic [31:0] o_perf_fetched, o_perf_bubbles;
`endif

    always #5 i_clk = ~i_clk;

    tl45_fetch #(.RESET_PC(32'h0)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pipe_stall (i_pipe_stall),
        .i_pipe_flush (i_pipe_flush),
        .i_new_pc     (i_new_pc),
        .o_buf_pc     (o_buf_pc),
        .o_buf_inst   (o_buf_inst),
        .o_fetch_err  (o_fetch_err),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_addr    (o_wb_addr),
        .i_wb_stall   (i_wb_stall),
        .i_wb_ack     (i_wb_ack),
        .i_wb_err     (i_wb_err),
        .i_wb_data    (i_wb_data)
`ifdef TL45_FETCH_PERF_EN
        ,
        .o_perf_fetched (o_perf_fetched),
        .o_perf_bubbles (o_perf_bubbles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration and state
    int          g_wait = 0;
    bit          g_rand = 1'b0;
    bit          g_err_en = 1'b0;
    logic [29:0] g_err_wa = 30'h0;
    bit          s_pend = 1'b0;
    logic [29:0] s_wa = 30'h0;
    int          s_delay = 0;
    int          s_stall_left = 0;
    int          s_accepts = 0;

    // Stream model
    logic [31:0] exp_pc = 32'h0;
    int          n_deliv = 0;
    int          m_fetched = 0;
    int          m_bubbles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        case (wa)
            30'd0:   return 32'h0810_0000;
            30'd1:   return 32'h1020_0000;
            30'd2:   return 32'h1830_0000;
            default: return {wa[27:0] ^ 28'h5A5_A5A5, 4'h9};
        endcase
    endfunction

    // Slave reacts to the DUT outputs that follow the edge just taken.
    task automatic slave_update();
        i_wb_ack   = 1'b0;
        i_wb_err   = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_data  = $urandom;
        if (s_pend) begin
            if (s_delay == 0) begin
                if (g_err_en && s_wa == g_err_wa) begin
                    i_wb_err  = 1'b1;
                    i_wb_data = 32'hDEAD_BEEF;
                end else begin
                    i_wb_ack  = 1'b1;
                    i_wb_data = mem_word(s_wa);
                end
                s_pend = 1'b0;
            end else if (!o_wb_cyc) begin
                s_pend = 1'b0;
            end else begin
                s_delay--;
            end
        end else if (o_wb_cyc && o_wb_stb) begin
            if (s_stall_left > 0) begin
                i_wb_stall = 1'b1;
                s_stall_left--;
            end else begin
                s_pend       = 1'b1;
                s_wa         = o_wb_addr;
                s_delay      = g_rand ? int'($urandom_range(0, 3)) : g_wait;
                s_stall_left = g_rand ? int'($urandom_range(0, 2)) : 0;
                s_accepts++;
            end
        end
    endtask

    // One clock: check what decode consumes at this edge, take the edge, check after it.
    task automatic step();
        bit          cons, hold_req;
        logic [29:0] addr_b;
        if (i_reset) begin
            exp_pc = 32'h0;
        end else if (i_pipe_flush) begin
            exp_pc = i_new_pc & 32'hFFFF_FFFC;
        end else if (!i_pipe_stall) begin
            if (o_buf_inst != 32'h0) begin
                chk("deliver_pc", o_buf_pc, exp_pc);
                chk("deliver_inst", o_buf_inst, mem_word(exp_pc[31:2]));
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end else begin
                chk("bubble_pc", o_buf_pc, 32'h0);
            end
        end
        if (i_wb_ack && o_wb_cyc && !i_pipe_flush && !i_reset) m_fetched++;
        cons     = !i_reset && !i_pipe_flush && !i_pipe_stall;
        hold_req = !i_reset && !i_pipe_flush && (o_wb_stb === 1'b1) && i_wb_stall;
        addr_b   = o_wb_addr;
        @(posedge i_clk);
        #1;
        if (cons && o_buf_inst == 32'h0) m_bubbles++;
        if (hold_req) begin
            chk("stb_hold", 32'(o_wb_stb), 32'h1);
            chk("addr_hold", 32'(o_wb_addr), 32'(addr_b));
        end
        slave_update();
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        cyc;
        logic        stb;
        logic [29:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int a0, cnt, d0;
        logic [29:0] saw_addr;
        bit found;

        // Reset followed by a zero-wait slave: pc 0,4,8 with a bubble in between.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 30'd0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 30'd0, 32'h0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 30'd1, 32'h0, 32'h0810_0000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 30'd1, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 30'd2, 32'h4, 32'h1020_0000};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 30'd2, 32'h0, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 30'd3, 32'h8, 32'h1830_0000};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 30'd3, 32'h0, 32'h0};

        i_reset = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            i_reset      = tbl[i].rst;
            i_pipe_stall = tbl[i].stall;
            step();
            chk($sformatf("tbl%0d_cyc", i), 32'(o_wb_cyc), 32'(tbl[i].cyc));
            chk($sformatf("tbl%0d_stb", i), 32'(o_wb_stb), 32'(tbl[i].stb));
            chk($sformatf("tbl%0d_addr", i), 32'(o_wb_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_pc", i), o_buf_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_inst", i), o_buf_inst, tbl[i].inst);
            chk($sformatf("tbl%0d_err", i), 32'(o_fetch_err), 32'h0);
        end

        // Decode stalls for 6 edges while two words return.
        a0 = s_accepts;
        i_pipe_stall = 1'b1;
        repeat (6) step();
        chk("stall_out_pc", o_buf_pc, 32'hC);
        chk("stall_out_inst", o_buf_inst, mem_word(30'd3));
        chk("stall_cyc", 32'(o_wb_cyc), 32'h0);
        chk("stall_stb", 32'(o_wb_stb), 32'h0);
        chk("stall_accepts", 32'(s_accepts - a0), 32'h1);
        i_pipe_stall = 1'b0;
        step();
        chk("skid_out_pc", o_buf_pc, 32'h10);
        chk("skid_out_inst", o_buf_inst, mem_word(30'd4));

        // Slave stalls the next request for 4 cycles.
        s_stall_left = 4;
        cnt = 0;
        saw_addr = 30'h0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_wb_stb) begin
                if (cnt == 0) saw_addr = o_wb_addr;
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
        end
        chk("wbstall_stb_cycles", 32'(cnt), 32'd5);
        chk("wbstall_addr", 32'(saw_addr), 32'd5);

        // Flush while waiting on a slow ack; the ack lands after cyc dropped.
        g_wait = 1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_pend && s_delay == 0 && o_wb_cyc) begin
                found = 1'b1;
                break;
            end
        end
        chk("flush_reach_wait", 32'(found), 32'h1);
        g_wait = 0;
        i_pipe_flush = 1'b1;
        i_new_pc = 32'h103;
        step();
        i_pipe_flush = 1'b0;
        chk("flush_cyc", 32'(o_wb_cyc), 32'h0);
        chk("flush_stb", 32'(o_wb_stb), 32'h0);
        chk("flush_buf_pc", o_buf_pc, 32'h0);
        chk("flush_buf_inst", o_buf_inst, 32'h0);
        step();
        chk("flush_restart_stb", 32'(o_wb_stb), 32'h1);
        chk("flush_restart_addr", 32'(o_wb_addr), 32'h40);
        chk("flush_late_ack_pc", o_buf_pc, 32'h0);
        chk("flush_late_ack_inst", o_buf_inst, 32'h0);

        // Bus error on the fetch of pc 0x20.
        g_err_wa = 30'h8;
        g_err_en = 1'b1;
        i_pipe_flush = 1'b1;
        i_new_pc = 32'h0;
        step();
        i_pipe_flush = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (o_fetch_err) begin
                found = 1'b1;
                break;
            end
        end
        chk("err_set", 32'(found), 32'h1);
        chk("err_cyc", 32'(o_wb_cyc), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("halt_stb", 32'(o_wb_stb), 32'h0);
            chk("halt_cyc", 32'(o_wb_cyc), 32'h0);
            chk("halt_sticky", 32'(o_fetch_err), 32'h1);
            chk("halt_bubble", o_buf_inst, 32'h0);
        end
        chk("err_stream_end", exp_pc, 32'h20);
        g_err_en = 1'b0;
        i_pipe_flush = 1'b1;
        i_new_pc = 32'h0;
        step();
        i_pipe_flush = 1'b0;
        chk("err_cleared", 32'(o_fetch_err), 32'h0);
        repeat (10) step();
        chk("err_resume", exp_pc, 32'h10);

        // PC wrap from the top of the address space.
        i_pipe_flush = 1'b1;
        i_new_pc = 32'hFFFF_FFFE;
        step();
        i_pipe_flush = 1'b0;
        repeat (8) step();
        chk("wrap_stream", exp_pc, 32'h8);

        // Random stall/flush traffic against a random-latency slave.
        g_rand = 1'b1;
        d0 = n_deliv;
        for (int k = 0; k < 3000; k++) begin
            i_pipe_stall = ($urandom_range(0, 99) < 30);
            i_pipe_flush = ($urandom_range(0, 99) < 2);
            i_new_pc     = $urandom;
            step();
        end
        i_pipe_stall = 1'b0;
        i_pipe_flush = 1'b0;
        g_rand = 1'b0;
        repeat (12) step();
        chk("random_progress", 32'(n_deliv - d0 > 100), 32'h1);

`ifdef TL45_FETCH_PERF_EN
        chk("perf_fetched", o_perf_fetched, 32'(m_fetched));
        chk("perf_bubbles", o_perf_bubbles, 32'(m_bubbles));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
